// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war key front end.
package tug_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

  // Default debounce length, also used by the board top.
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // Counter width large enough to hold the largest of the three limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop synchroniser, debounce FSM, registered press pulse.
// Optional auto-repeat while the key stays held, enabled by AUTOREPEAT_EN.
module key_channel
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  input  logic enable,
  output logic press,
  output logic held
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          press_q, press_d;
  logic          pressed;
  logic          accept;
  logic          rpt_fire;

  assign pressed = ~sync2_q;
  // Saturating increment; IDLE and HELD hold cnt at 0 so this yields 1 there.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State register: synchroniser, FSM state, debounce counter, pulse flop
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Next-state: count consecutive samples that disagree with the accepted level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB) begin
          state_d = HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          state_d = PRESS_WAIT;
          cnt_d   = cnt_inc;
        end
      end
      HELD, RELEASE_WAIT: begin
        if (pressed) begin
          // bounce during release lands back in HELD without a pulse
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = RELEASE_WAIT;
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER = CW'(REPEAT_PERIOD);

  logic [CW-1:0] rpt_q, rpt_d, rpt_inc, rpt_tgt;
  logic          rep_q, rep_d;   // first repeat already issued

  assign rpt_inc = (rpt_q == '1) ? rpt_q : rpt_q + 1'b1;
  assign rpt_tgt = rep_q ? PER : DLY;

  // Repeat counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      rep_q <= rep_d;
    end
  end

  // Repeat counter: runs only on edges that stay in HELD, frozen in RELEASE_WAIT
  always_comb begin
    rpt_d    = rpt_q;
    rep_d    = rep_q;
    rpt_fire = 1'b0;
    if (accept || state_d == IDLE) begin
      rpt_d = '0;
      rep_d = 1'b0;
    end else if (state_q == HELD && state_d == HELD) begin
      if (rpt_inc >= rpt_tgt) begin
        rpt_fire = 1'b1;
        rpt_d    = '0;
        rep_d    = 1'b1;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Outputs: pulse gated by enable at the deciding edge; held from state
  always_comb begin
    press_d = enable & (accept | rpt_fire);
    held    = (state_q == HELD) || (state_q == RELEASE_WAIT);
  end

  assign press = press_q;

endmodule

// File: rtl/key_press_conditioner.sv
// Tug-of-war key front end: two independent key channels (left, right) that
// turn raw active-low buttons into one-cycle press pulses and held flags.
// Optional auto-repeat selected by the AUTOREPEAT_EN macro.
module key_press_conditioner
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic l_press,
  output logic r_press,
  output logic l_held,
  output logic r_held
);

  // index 1 = left, index 0 = right
  logic [1:0] key_n, press, held;

  assign key_n = {key_l_n, key_r_n};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .key_n (key_n[g]),
      .enable(enable),
      .press (press[g]),
      .held  (held[g])
    );
  end

  assign l_press = press[1];
  assign r_press = press[0];
  assign l_held  = held[1];
  assign r_held  = held[0];

endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner: directed scenarios plus random key bouncing,
// compared each cycle against a debounced-level / hold-time reference model.
module tb_key_press_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clock = 1'b0;
  logic reset, key_l_n, key_r_n, enable;
  logic l_press, r_press, l_held, r_held;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model, index 0 = left, 1 = right
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_acc[2];   // accepted (debounced) level: 1 = pressed
  int m_run[2];   // consecutive samples disagreeing with m_acc
  int m_ht [2];   // edges spent staying in the held-and-stable condition
  bit m_p  [2];   // expected press output after this edge

  always #5 clock = ~clock;

  key_press_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .key_l_n(key_l_n),
    .key_r_n(key_r_n),
    .enable (enable),
    .l_press(l_press),
    .r_press(r_press),
    .l_held (l_held),
    .r_held (r_held)
  );

  task automatic model_ch(input int i, input bit raw);
    bit pr, fire, stable_held;
    if (reset) begin
      m_s1[i] = 1; m_s2[i] = 1; m_acc[i] = 0; m_run[i] = 0; m_ht[i] = 0; m_p[i] = 0;
      return;
    end
    pr          = !m_s2[i];
    fire        = 0;
    stable_held = m_acc[i] && (m_run[i] == 0);
    if (pr == m_acc[i]) m_run[i] = 0;
    else begin
      m_run[i]++;
      if (m_run[i] >= D) begin
        m_acc[i] = !m_acc[i];
        m_run[i] = 0;
        m_ht[i]  = 0;
        if (m_acc[i]) fire = 1;
      end
    end
`ifdef AUTOREPEAT_EN
    if (stable_held && pr) begin
      m_ht[i]++;
      if (m_ht[i] == RD || (m_ht[i] > RD && (m_ht[i] - RD) % RP == 0)) fire = 1;
    end
`else
    if (stable_held && pr) m_ht[i]++;
`endif
    m_p[i]  = enable && fire;
    m_s2[i] = m_s1[i];
    m_s1[i] = raw;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge
  task automatic tick();
    @(posedge clock);
    model_ch(0, key_l_n);
    model_ch(1, key_r_n);
    cyc++;
    @(negedge clock);
    chk("l_press", l_press, m_p[0]);
    chk("r_press", r_press, m_p[1]);
    chk("l_held",  l_held,  m_acc[0]);
    chk("r_held",  r_held,  m_acc[1]);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int first, cnt, exp_cnt;
    reset = 1; key_l_n = 1; key_r_n = 1; enable = 1;
    ticks(3);
    chk("reset_l_press", l_press, 1'b0);
    chk("reset_l_held",  l_held,  1'b0);
    reset = 0;
    ticks(9);

    // 1: clean left press, check latency and pulse count
    key_l_n = 0;
    first = 0; cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 21) key_l_n = 1;
      tick();
      if (l_press === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
`ifdef AUTOREPEAT_EN
    exp_cnt = 4;
`else
    exp_cnt = 1;
`endif
    chk_int("t1_latency", first, D + 2);
    chk_int("t1_count", cnt, exp_cnt);

    // 2: press bounce then steady
    key_l_n = 0; ticks(2); key_l_n = 1; ticks(2);
    key_l_n = 0; ticks(12); key_l_n = 1; ticks(10);

    // 3: release bounce after a press
    key_l_n = 0; ticks(10); key_l_n = 1; ticks(2);
    key_l_n = 0; ticks(8);  key_l_n = 1; ticks(10);

    // 4: simultaneous presses
    key_l_n = 0; key_r_n = 0; ticks(10);
    key_l_n = 1; key_r_n = 1; ticks(10);

    // 5: enable low across the accept edge, then re-press
    enable = 0; key_l_n = 0; ticks(8);
    enable = 1; ticks(6);
    key_l_n = 1; ticks(10);
    key_l_n = 0; ticks(10);
    key_l_n = 1; ticks(10);

    // 5b: reset in the middle of PRESS_WAIT
    key_r_n = 0; ticks(3);
    reset = 1; tick();
    chk("rst_mid_r_press", r_press, 1'b0);
    chk("rst_mid_r_held",  r_held,  1'b0);
    reset = 0; key_r_n = 1; ticks(10);

    // 6: long hold (repeat behaviour when enabled)
    key_r_n = 0; ticks(40);
    enable = 0; ticks(7); enable = 1; ticks(5);
    key_r_n = 1; ticks(2); key_r_n = 0; ticks(8);
    key_r_n = 1; ticks(12);

    // Random bouncing keys, occasional enable drops and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) key_l_n = ~key_l_n;
      if ($urandom_range(0, 5) == 0) key_r_n = ~key_r_n;
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0;
    ticks(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
